// File: rtl/mem_loader_pkg.sv
// Shared constants, state encodings and address helper for the mem_loader slice.
package mem_loader_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [31:0] ADDR_STEP      = 32'd4;
  localparam logic [2:0]  SW_FUNCT3      = 3'b010;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] cnt);
    return base + cnt * ADDR_STEP;
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream input, data-memory write port and status of the loader, as one bundle.
interface mem_loader_if #(parameter int CW = 7) ();

  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          cpu_reset;
  logic          Ext_MemWrite;
  logic [31:0]   Ext_DataAdr;
  logic [31:0]   Ext_WriteData;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] word_cnt;

  modport master (
    input  start, in_valid, in_data,
    output in_ready, cpu_reset, Ext_MemWrite, Ext_DataAdr, Ext_WriteData,
           busy, done, err, word_cnt
  );

  modport slave (
    output start, in_valid, in_data,
    input  in_ready, cpu_reset, Ext_MemWrite, Ext_DataAdr, Ext_WriteData,
           busy, done, err, word_cnt
  );

endinterface

// File: rtl/mem_loader_byte_packer.sv
// Packs bytes little-endian into a 32-bit word; o_full flags the load that completes the word.
module mem_loader_byte_packer
  import mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_full
);

  localparam int IW = $clog2(BYTES_PER_WORD);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES_PER_WORD - 1);

  logic [IW-1:0] r_idx;
  logic [31:0]   r_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
    end else if (i_load) begin
      r_word[8*r_idx +: 8] <= i_byte;
      r_idx                <= r_idx + IW'(1);
    end
  end

  assign o_word = r_word;
  assign o_full = i_load && (r_idx == LAST_IDX);

endmodule

// File: rtl/mem_loader.sv
// Streams bytes into sequential data-memory words while holding the CPU in reset.
// Optional trailer checksum is enabled with `define MEM_LOADER_CHECKSUM_EN.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          WORD_COUNT = 64
) (
  input  logic         clk,
  input  logic         reset,
  mem_loader_if.master bus
);

  localparam int CW = $clog2(WORD_COUNT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WORD_COUNT);

  logic [2:0]    r_state;
  logic [CW-1:0] r_word_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_start_ok;
  logic          w_accept;
  logic          w_clear;
  logic          w_full;
  logic [31:0]   w_word;

  assign w_start_ok = bus.start &&
                      (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
  assign w_accept   = bus.in_valid && bus.in_ready;
  assign w_clear    = w_start_ok || (r_state == S_WRITE);
  assign w_cnt_nxt  = r_word_cnt + CW'(1);

  mem_loader_byte_packer u_packer (
    .clk     (clk),
    .rst_n   (reset),
    .i_clear (w_clear),
    .i_load  (w_accept && (r_state == S_COLLECT)),
    .i_byte  (bus.in_data),
    .o_word  (w_word),
    .o_full  (w_full)
  );

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sum_nxt;

  assign w_sum_nxt = r_sum + bus.in_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum <= '0;
    end else if (w_start_ok) begin
      r_sum <= '0;
    end else if (w_accept && (r_state == S_COLLECT)) begin
      r_sum <= w_sum_nxt;
    end
  end

  assign bus.in_ready = (r_state == S_COLLECT) || (r_state == S_CHECK);
  assign bus.err      = (r_state == S_ERROR);
`else
  assign bus.in_ready = (r_state == S_COLLECT);
  assign bus.err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_word_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (w_start_ok) begin
            r_word_cnt <= '0;
            r_state    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_full) r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_word_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == LAST_CNT) begin
`ifdef MEM_LOADER_CHECKSUM_EN
            r_state <= S_CHECK;
`else
            r_state <= S_DONE;
`endif
          end else begin
            r_state <= S_COLLECT;
          end
        end
`ifdef MEM_LOADER_CHECKSUM_EN
        // The trailer byte must bring the running sum of the whole load to zero.
        S_CHECK: begin
          if (w_accept) r_state <= (w_sum_nxt == 8'h00) ? S_DONE : S_ERROR;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_reset     = (r_state != S_DONE);
  assign bus.Ext_MemWrite  = (r_state == S_WRITE);
  assign bus.Ext_DataAdr   = word_addr(BASE_ADDR, 32'(r_word_cnt));
  assign bus.Ext_WriteData = w_word;
  assign bus.busy          = (r_state == S_COLLECT) || (r_state == S_WRITE) ||
                             (r_state == S_CHECK);
  assign bus.done          = (r_state == S_DONE);
  assign bus.word_cnt      = r_word_cnt;

endmodule
